// File: rtl/comparador_serial.sv
// Serial MSB-first magnitude comparator: one bit per clock, first difference wins.
// Supports unsigned/two's-complement operands and optional early exit on the first differing bit.
module comparador_serial #(
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inicio,
  input  logic [K-1:0] A,
  input  logic [K-1:0] B,
  input  logic         con_signo,
  input  logic         temprana,
  output logic         listo,
  output logic         valido,
  output logic         mayor,
  output logic         menor,
  output logic         igual
);

  localparam int IW = $clog2(K);
  localparam logic [IW-1:0] I_MSB = IW'(K - 1);

  typedef enum logic [1:0] {REPOSO, COMPARA, FIN} estado_t;

  estado_t       estado, siguiente;
  logic [K-1:0]  ar, br;
  logic          sr, tr;
  logic [IW-1:0] i;
  logic          m, n;
  logic          m_nx, n_nx;
  logic          cierra;

  always_ff @(posedge clk) begin
    if (reset) estado <= REPOSO;
    else       estado <= siguiente;
  end

  always_comb begin
    siguiente = estado;
    listo     = 1'b0;
    valido    = 1'b0;
    m_nx      = m;
    n_nx      = n;
    cierra    = 1'b0;
    case (estado)
      REPOSO: begin
        listo = 1'b1;
        if (inicio) siguiente = COMPARA;
      end
      COMPARA: begin
        // In signed mode the sign bit carries inverted weight, so its sense flips.
        if (!m && !n) begin
          if (sr && i == I_MSB) begin
            m_nx = ~ar[i] & br[i];
            n_nx = ar[i] & ~br[i];
          end else begin
            m_nx = ar[i] & ~br[i];
            n_nx = ~ar[i] & br[i];
          end
        end
        cierra = (i == '0) || (tr && (m_nx || n_nx));
        if (cierra) siguiente = FIN;
      end
      FIN: begin
        valido    = 1'b1;
        siguiente = REPOSO;
      end
      default: siguiente = REPOSO;
    endcase
  end

  // Results load on the FIN-entry edge so they are already stable while valido is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      ar    <= '0;
      br    <= '0;
      sr    <= 1'b0;
      tr    <= 1'b0;
      i     <= '0;
      m     <= 1'b0;
      n     <= 1'b0;
      mayor <= 1'b0;
      menor <= 1'b0;
      igual <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          if (inicio) begin
            ar <= A;
            br <= B;
            sr <= con_signo;
            tr <= temprana;
            i  <= I_MSB;
            m  <= 1'b0;
            n  <= 1'b0;
          end
        end
        COMPARA: begin
          m <= m_nx;
          n <= n_nx;
          if (cierra) begin
            mayor <= m_nx;
            menor <= n_nx;
            igual <= ~(m_nx | n_nx);
          end else begin
            i <= i - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
